uart_tx_sub: RTL and testbench
==============================

# uart_tx_sub

Parametrised UART transmit subsystem: a write-side FIFO, a runtime-programmable baud prescaler and a framing FSM in one block. It is the next generation of the fixed 8N1 / fixed-divisor transmit top. It adds configurable data width, FIFO depth, parity and stop bits, plus occupancy and overflow status. It sits between the host write port and the serial `tx` pin.

## Interface
- `DATA_W`, 8: data bits per frame; legal range 5..8.
- `FIFO_DEPTH`, 16: FIFO entries; power of two, ≥2.
- `DVSR_W`, 11: width of the divisor input.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `dvsr`  in  DVSR_W  prescaler divisor; one tick every `dvsr+1` clocks.
- `parity_en`  in  1  1 = append parity bit.
- `parity_odd`  in  1  1 = odd parity, 0 = even.
- `two_stop`  in  1  1 = two stop bits, 0 = one.
- `wr_en`  in  1  push `d_in` into FIFO.
- `d_in`  in  DATA_W  write data.
- `tx_full`  out  1  FIFO full.
- `tx_empty`  out  1  FIFO empty.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- `overflow`  out  1  sticky; set when a write is dropped.
- `tx_busy`  out  1  FSM not in IDLE.
- `frame_done`  out  1  one-cycle pulse at the end of each frame.
- `tx`  out  1  serial line, idle high.

## Operation
- Reset values: `tx`=1, `tx_full`=0, `tx_empty`=1, `fifo_count`=0, `overflow`=0, `tx_busy`=0, `frame_done`=0.
- Reset clears FIFO pointers, prescaler, bit counters and FSM. Reset mid-frame drives `tx`=1 on the next cycle and discards the partial frame.
- FIFO:
  - `wr_en` with not full: the word is stored and `fifo_count` increments next cycle.
  - `wr_en` with full: the word is dropped and `overflow` sets. This applies even if a pop occurs in the same cycle.
  - Simultaneous push and pop (not full): `fifo_count` is unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
- Prescaler:
  - Counts 0..`dvsr` and emits a tick when the count equals `dvsr`.
  - Held at 0 in IDLE. Cleared at the start of every bit.
  - Each bit is exactly 16 ticks = 16·(`dvsr`+1) clocks.
- Frame start (the pop cycle):
  - `dvsr`, `parity_en`, `parity_odd` and `two_stop` are latched.
  - The head word is loaded into the shift register.
  - Changes to these inputs mid-frame take effect on the next frame only.
- FSM states and transitions:
  - IDLE → START when `fifo_count`≠0. The FSM pops in that cycle.
  - START → DATA: `tx`=0 for 1 bit.
  - DATA → PARITY if `parity_en`, else → STOP. `DATA_W` bits, LSB first.
  - PARITY → STOP. Parity bit = XOR(data) ^ `parity_odd`.
  - STOP: `tx`=1 for 1 or 2 bits.
- On the last clock of STOP:
  - `frame_done` pulses.
  - If the FIFO is non-empty, the FSM pops and goes straight to START, with no idle cycle between frames.
  - Otherwise it goes to IDLE.
- `tx` is driven from a register and is glitch-free.

## Timing
- `wr_en` into an empty, idle block at cycle N:
  - `fifo_count`=1 at N+1.
  - Pop at N+1.
  - `tx`=0 from N+2.
- Frame length = (1 + `DATA_W` + `parity_en` + 1 + `two_stop`) · 16 · (`dvsr`+1) clocks.
- `tx_busy` rises the cycle `tx` first goes low. It falls the cycle after the last stop clock if the FIFO is empty.
- `tx_full` and `tx_empty` are registered with `fifo_count` and change the cycle after the causing push or pop.
- `dvsr`=0 is legal: 16-clock bits.

## Test plan
- Idle/reset: after reset with no writes, check `tx`=1, `tx_empty`=1, `fifo_count`=0, `tx_busy`=0 for 1000 cycles.
- Basic 8N1, `dvsr`=0: write 0xA5 at cycle N.
  - `tx` low for N+2..N+17.
  - Data bits 1,0,1,0,0,1,0,1, 16 cycles each.
  - Stop high for 16 cycles; `frame_done` at N+161.
- Parity and stop bits, `dvsr`=1, `parity_en`=1, `two_stop`=1:
  - 0xA5 with `parity_odd`=0 → parity bit 0; with `parity_odd`=1 → parity bit 1.
  - Frame is 12·32 = 384 clocks.
- Back-to-back: write 0x01, 0x02, 0x03 on consecutive cycles with 8N1, `dvsr`=0.
  - Exactly 3 `frame_done` pulses, 160 cycles apart.
  - No idle-high cycle between stop and next start.
- Full/overflow, `FIFO_DEPTH`=4: while the first frame transmits, write 6 words.
  - `tx_full`=1 once 4 are queued.
  - The excess write is dropped and `overflow`=1 and stays set.
  - Only 5 frames are transmitted in total (1 in flight + 4 queued).
- Reset mid-frame: assert `reset` during DATA of 0x55.
  - Next cycle: `tx`=1, `fifo_count`=0, `overflow`=0.
  - A subsequent write transmits a complete, correct frame.

Source files
------------

// File: rtl/uart_tx_sub_if.sv
// Host write port of the UART transmit subsystem: push strobe, data and FIFO status.
interface uart_tx_sub_if #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16
);
    logic                          wr_en;
    logic [DATA_W-1:0]             d_in;
    logic                          tx_full;
    logic                          tx_empty;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          overflow;

    modport master (
        output wr_en, d_in,
        input  tx_full, tx_empty, fifo_count, overflow
    );

    modport slave (
        input  wr_en, d_in,
        output tx_full, tx_empty, fifo_count, overflow
    );
endinterface

// File: rtl/uart_tx_sub.sv
// UART transmitter: write FIFO, programmable x16 prescaler and framing FSM
// with configurable parity and stop bits; frames run back-to-back while data is queued.
module uart_tx_sub #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DVSR_W     = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DVSR_W-1:0] dvsr,
    input  logic              parity_en,
    input  logic              parity_odd,
    input  logic              two_stop,
    uart_tx_sub_if.slave      wr_port,
    output logic              tx_busy,
    output logic              frame_done,
    output logic              tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(DATA_W);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

    state_e              state_q, state_d;
    logic [DVSR_W-1:0]   psc_q, psc_d;
    logic [3:0]          tick16_q, tick16_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [DATA_W-1:0]   sh_q, sh_d;
    logic                par_q, par_d;
    logic [DVSR_W-1:0]   dvsr_q, dvsr_d;
    logic                pen_q, pen_d;
    logic                two_q, two_d;
    logic                tx_q, tx_d;

    logic [DATA_W-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]       wptr_q, rptr_q;
    logic [CW-1:0]       count_q;
    logic                ovf_q;
    logic                full, push, pop, load, done, tick, bit_end;

    assign full = (count_q == CW'(FIFO_DEPTH));
    assign push = wr_port.wr_en && !full;

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            count_q <= count_q + CW'(push) - CW'(pop);
            if (wr_port.wr_en && full) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr_q] <= wr_port.d_in;
    end

    always_comb begin
        state_d  = state_q;
        psc_d    = psc_q;
        tick16_d = tick16_q;
        bit_d    = bit_q;
        sh_d     = sh_q;
        par_d    = par_q;
        dvsr_d   = dvsr_q;
        pen_d    = pen_q;
        two_d    = two_q;
        load     = 1'b0;
        pop      = 1'b0;
        done     = 1'b0;
        tick     = (psc_q == dvsr_q);
        bit_end  = tick && (tick16_q == 4'hF);

        if (state_q == IDLE) begin
            psc_d    = '0;
            tick16_d = '0;
        end else begin
            psc_d = tick ? '0 : psc_q + 1'b1;
            if (tick) tick16_d = tick16_q + 4'd1;
        end

        case (state_q)
            IDLE:   load = (count_q != '0);
            START:  if (bit_end) begin
                        state_d = DATA;
                        bit_d   = '0;
                    end
            DATA:   if (bit_end) begin
                        sh_d = sh_q >> 1;
                        if (bit_q == BW'(DATA_W - 1)) begin
                            bit_d   = '0;
                            state_d = pen_q ? PARITY : STOP;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end
            PARITY: if (bit_end) state_d = STOP;
            STOP:   if (bit_end) begin
                        if (two_q && bit_q == '0) begin
                            bit_d = BW'(1);
                        end else begin
                            done = 1'b1;
                            if (count_q != '0) load = 1'b1;
                            else               state_d = IDLE;
                        end
                    end
            default: state_d = IDLE;
        endcase

        if (load) begin
            pop      = 1'b1;
            state_d  = START;
            bit_d    = '0;
            psc_d    = '0;
            tick16_d = '0;
            sh_d     = mem[rptr_q];
            par_d    = (^mem[rptr_q]) ^ parity_odd;
            dvsr_d   = dvsr;
            pen_d    = parity_en;
            two_d    = two_stop;
        end

        // tx is registered from the next-state view so the line changes with the state
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = sh_d[0];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            psc_q    <= '0;
            tick16_q <= '0;
            bit_q    <= '0;
            sh_q     <= '0;
            par_q    <= 1'b0;
            dvsr_q   <= '0;
            pen_q    <= 1'b0;
            two_q    <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            psc_q    <= psc_d;
            tick16_q <= tick16_d;
            bit_q    <= bit_d;
            sh_q     <= sh_d;
            par_q    <= par_d;
            dvsr_q   <= dvsr_d;
            pen_q    <= pen_d;
            two_q    <= two_d;
            tx_q     <= tx_d;
        end
    end

    assign tx                 = tx_q;
    assign tx_busy            = (state_q != IDLE);
    assign frame_done         = done;
    assign wr_port.tx_full    = full;
    assign wr_port.tx_empty   = (count_q == '0);
    assign wr_port.fifo_count = count_q;
    assign wr_port.overflow   = ovf_q;
endmodule

// File: tb/tb_uart_tx_sub.sv
// Scoreboard bench for uart_tx_sub: expected frames are queued at write time and a
// line monitor decodes tx and checks each frame, including its frame_done position.
module tb_uart_tx_sub;
    logic        clk;
    logic        reset;
    logic [10:0] dvsr;
    logic        parity_en, parity_odd, two_stop;
    logic        tx_busy, frame_done, tx;

    uart_tx_sub_if #(.DATA_W(8), .FIFO_DEPTH(4)) wif ();

    uart_tx_sub #(.DATA_W(8), .FIFO_DEPTH(4), .DVSR_W(11)) dut (
        .clk        (clk),
        .reset      (reset),
        .dvsr       (dvsr),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .two_stop   (two_stop),
        .wr_port    (wif),
        .tx_busy    (tx_busy),
        .frame_done (frame_done),
        .tx         (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       par_en;
        logic       par_bit;
        logic       two_stop;
        int         dvsr;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   done_cyc[$];
    logic mon_en;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_frame(input logic [7:0] d, input logic pe, input logic pb,
                                input logic ts, input int dv);
        exp_t e;
        e.data = d; e.par_en = pe; e.par_bit = pb; e.two_stop = ts; e.dvsr = dv;
        sb.push_back(e);
    endtask

    // called at a negedge; returns at the negedge after the sampling edge
    task automatic wr(input logic [7:0] d);
        wif.wr_en = 1'b1;
        wif.d_in  = d;
        @(negedge clk);
        wif.wr_en = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("frames_done", done_cnt, target);
    endtask

    always @(negedge clk) begin
        cyc++;
        if (frame_done === 1'b1) begin
            done_cnt++;
            done_cyc.push_back(cyc);
        end
    end

    // line monitor: decode one frame at bit centres, compare against the scoreboard head
    exp_t       m_e;
    int         m_bp;
    logic [7:0] m_got;
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && tx === 1'b0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_frame", 32'd1, 32'd0);
                    repeat (200) @(negedge clk);
                end else begin
                    m_e  = sb.pop_front();
                    m_bp = 16 * (m_e.dvsr + 1);
                    repeat (m_bp / 2) @(negedge clk);
                    chk("start_bit", tx, 1'b0);
                    for (int i = 0; i < 8; i++) begin
                        repeat (m_bp) @(negedge clk);
                        m_got[i] = tx;
                    end
                    chk("data_byte", m_got, m_e.data);
                    if (m_e.par_en) begin
                        repeat (m_bp) @(negedge clk);
                        chk("parity_bit", tx, m_e.par_bit);
                    end
                    repeat (m_bp) @(negedge clk);
                    chk("stop_bit1", tx, 1'b1);
                    if (m_e.two_stop) begin
                        repeat (m_bp) @(negedge clk);
                        chk("stop_bit2", tx, 1'b1);
                    end
                    repeat (m_bp / 2 - 1) @(negedge clk);
                    chk("frame_done_at_last_stop_clock", frame_done, 1'b1);
                end
            end
        end
    end

    int bad;
    int base;
    initial begin
        reset = 1'b1; wif.wr_en = 1'b0; wif.d_in = '0;
        dvsr = '0; parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
        mon_en = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        chk("rst_tx", tx, 1'b1);
        chk("rst_full", wif.tx_full, 1'b0);
        chk("rst_empty", wif.tx_empty, 1'b1);
        chk("rst_count", wif.fifo_count, 0);
        chk("rst_overflow", wif.overflow, 1'b0);
        chk("rst_busy", tx_busy, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);

        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (tx !== 1'b1 || wif.tx_empty !== 1'b1 || wif.fifo_count !== 3'd0 || tx_busy !== 1'b0)
                bad++;
        end
        chk("idle_bad_cycles", bad, 0);

        // basic 8N1, dvsr=0
        expect_frame(8'hA5, 1'b0, 1'b0, 1'b0, 0);
        base = done_cnt;
        wr(8'hA5);
        chk("count_after_write", wif.fifo_count, 3'd1);
        chk("tx_high_before_start", tx, 1'b1);
        @(negedge clk);
        chk("tx_low_at_start", tx, 1'b0);
        chk("busy_at_start", tx_busy, 1'b1);
        chk("count_after_pop", wif.fifo_count, 3'd0);
        wait_frames(base + 1, 400);
        repeat (3) @(negedge clk);
        chk("busy_after_frame", tx_busy, 1'b0);

        // parity + two stop bits, dvsr=1; parity_odd changed mid-frame hits next frame only
        dvsr = 11'd1; parity_en = 1'b1; two_stop = 1'b1; parity_odd = 1'b0;
        expect_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1);
        expect_frame(8'hA5, 1'b1, 1'b1, 1'b1, 1);
        base = done_cnt;
        wr(8'hA5);
        repeat (5) @(negedge clk);
        parity_odd = 1'b1;
        wr(8'hA5);
        wait_frames(base + 2, 1000);
        if (done_cyc.size() >= 2)
            chk("parity_frame_len", done_cyc[done_cyc.size()-1] - done_cyc[done_cyc.size()-2], 384);

        // back-to-back 8N1
        dvsr = '0; parity_en = 1'b0; two_stop = 1'b0; parity_odd = 1'b0;
        expect_frame(8'h01, 1'b0, 1'b0, 1'b0, 0);
        expect_frame(8'h02, 1'b0, 1'b0, 1'b0, 0);
        expect_frame(8'h03, 1'b0, 1'b0, 1'b0, 0);
        base = done_cnt;
        wr(8'h01); wr(8'h02); wr(8'h03);
        wait_frames(base + 3, 700);
        if (done_cyc.size() >= 3) begin
            chk("b2b_gap_1_2", done_cyc[done_cyc.size()-2] - done_cyc[done_cyc.size()-3], 160);
            chk("b2b_gap_2_3", done_cyc[done_cyc.size()-1] - done_cyc[done_cyc.size()-2], 160);
        end
        repeat (400) @(negedge clk);
        chk("b2b_frame_total", done_cnt, base + 3);

        // full / overflow with depth 4
        expect_frame(8'h10, 1'b0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 4; i++) expect_frame(8'h11 + 8'(i), 1'b0, 1'b0, 1'b0, 0);
        base = done_cnt;
        wr(8'h10);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            wr(8'h11 + 8'(i));
            if (i == 2) chk("not_full_at_3", wif.tx_full, 1'b0);
            if (i == 3) chk("full_at_4", wif.tx_full, 1'b1);
        end
        chk("count_when_full", wif.fifo_count, 3'd4);
        chk("overflow_set", wif.overflow, 1'b1);
        wait_frames(base + 5, 1200);
        repeat (400) @(negedge clk);
        chk("overflow_frame_total", done_cnt, base + 5);
        chk("overflow_sticky", wif.overflow, 1'b1);
        chk("empty_after_drain", wif.tx_empty, 1'b1);

        // reset in the middle of a frame
        mon_en = 1'b0;
        wr(8'h55);
        wr(8'h66);
        repeat (40) @(negedge clk);
        chk("busy_mid_frame", tx_busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_tx", tx, 1'b1);
        chk("midrst_count", wif.fifo_count, 3'd0);
        chk("midrst_overflow", wif.overflow, 1'b0);
        chk("midrst_busy", tx_busy, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;
        expect_frame(8'h3C, 1'b0, 1'b0, 1'b0, 0);
        base = done_cnt;
        wr(8'h3C);
        wait_frames(base + 1, 400);

        repeat (20) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
